// File: rtl/ap_ctrl_driver.sv
// rtl/ap_ctrl_driver.sv - ap_ctrl_chain initiator with start timestamp FIFO and latency statistics.
// Optional idle watchdog enabled by defining AP_CTRL_DRIVER_TIMEOUT_EN.

module ap_ctrl_ts_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   fill,
   output logic                         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head  = mem[rd_ptr];
   assign empty = (fill == '0);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         fill <= fill + FW'(push) - FW'(pop);
      end
   end
endmodule

module ap_ctrl_driver #(
   parameter int CNT_W        = 32,
   parameter int LAT_W        = 24,
   parameter int MAX_INFLIGHT = 4,
   parameter int TIMEOUT      = 1024
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CNT_W-1:0]         cmd_count,
   input  logic                     cons_stall,
   output logic                     ap_start,
   input  logic                     ap_ready,
   input  logic                     ap_done,
   output logic                     ap_continue,
   output logic                     busy,
   output logic                     run_done,
   output logic [CNT_W-1:0]         starts_issued,
   output logic [CNT_W-1:0]         dones_seen,
   output logic [LAT_W-1:0]         lat_min,
   output logic [LAT_W-1:0]         lat_max,
   output logic [CNT_W+LAT_W-1:0]   lat_sum,
   output logic                     err,
   output logic                     timeout
);
   localparam int OW = $clog2(MAX_INFLIGHT + 1);
   localparam int SW = CNT_W + LAT_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                start_q;
   logic                start_nxt;
   logic                run_done_q;
   logic                err_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    starts_q;
   logic [CNT_W-1:0]    starts_nxt;
   logic [CNT_W-1:0]    dones_q;
   logic [LAT_W-1:0]    ts;
   logic [LAT_W-1:0]    head;
   logic [LAT_W-1:0]    latency;
   logic [LAT_W-1:0]    min_q;
   logic [LAT_W-1:0]    max_q;
   logic [SW-1:0]       sum_q;
   logic [SW:0]         sum_add;
   logic [OW-1:0]       fill;
   logic [OW-1:0]       fill_nxt;
   logic                empty;
   logic                cmd_acc;
   logic                start_acc;
   logic                done_acc;
   logic                done_ok;
   logic                push;
   logic                pop;
   logic                wd_fire;

   assign cmd_ready   = (state == S_IDLE);
   assign cmd_acc     = cmd_valid && cmd_ready;
   assign busy        = (state == S_RUN) || (state == S_DRAIN);
   assign ap_continue = busy && !cons_stall;
   assign ap_start    = start_q;
   assign run_done    = run_done_q;
   assign err         = err_q;

   assign start_acc = start_q && ap_ready;
   assign done_acc  = ap_done && ap_continue;
   // A done with nothing outstanding is only legal when a start lands in the same cycle.
   assign done_ok   = done_acc && (!empty || start_acc);
   assign push      = start_acc && !(done_acc && empty);
   assign pop       = done_acc && !empty;
   assign latency   = empty ? '0 : ts - head;
   assign sum_add   = {1'b0, sum_q} + {{(CNT_W + 1){1'b0}}, latency};

   assign starts_nxt = starts_q + CNT_W'(start_acc);
   assign fill_nxt   = fill + OW'(push) - OW'(pop);

   assign starts_issued = starts_q;
   assign dones_seen    = dones_q;
   assign lat_min       = (dones_q == '0) ? '0 : min_q;
   assign lat_max       = max_q;
   assign lat_sum       = sum_q;

   ap_ctrl_ts_fifo #(
      .DEPTH (MAX_INFLIGHT),
      .W     (LAT_W)
   ) u_ts_fifo (
      .clock (clock),
      .reset (reset),
      .clear (cmd_acc),
      .push  (push),
      .pop   (pop),
      .wdata (ts),
      .head  (head),
      .fill  (fill),
      .empty (empty)
   );

`ifdef AP_CTRL_DRIVER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_q;
   logic          timeout_q;

   assign wd_fire = busy && !start_acc && !done_acc && (wd_q == WW'(TIMEOUT - 1));
   assign timeout = timeout_q;

   always_ff @(posedge clock) begin
      if (reset || cmd_acc || !busy || start_acc || done_acc) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || cmd_acc) begin
         timeout_q <= 1'b0;
      end else if (wd_fire) begin
         timeout_q <= 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = (TIMEOUT != 0);
   assign wd_fire    = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      start_nxt = 1'b0;
      case (state)
         S_IDLE:  if (cmd_acc) state_nxt = (cmd_count == '0) ? S_DONE : S_RUN;
         S_RUN:   if (starts_q == count_q) state_nxt = S_DRAIN;
         S_DRAIN: if (dones_q == count_q) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Post-accept counts decide whether a fresh start may follow back-to-back.
      if (start_q && !ap_ready) begin
         start_nxt = 1'b1;
      end else begin
         start_nxt = (state == S_RUN) && (starts_nxt < count_q) && (fill_nxt < OW'(MAX_INFLIGHT));
      end
      if (wd_fire) begin
         state_nxt = S_DONE;
         start_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         run_done_q <= 1'b0;
         ts         <= '0;
         count_q    <= '0;
         starts_q   <= '0;
         dones_q    <= '0;
         min_q      <= '0;
         max_q      <= '0;
         sum_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         start_q    <= start_nxt;
         run_done_q <= (state == S_DONE);
         ts         <= ts + 1'b1;
         if (cmd_acc) begin
            count_q  <= cmd_count;
            starts_q <= '0;
            dones_q  <= '0;
            min_q    <= '1;
            max_q    <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
         end else begin
            starts_q <= starts_nxt;
            if (done_ok) begin
               dones_q <= dones_q + 1'b1;
               if (latency < min_q) begin
                  min_q <= latency;
               end
               if (latency > max_q) begin
                  max_q <= latency;
               end
               sum_q <= sum_add[SW] ? '1 : sum_add[SW-1:0];
            end
            if (done_acc && !done_ok) begin
               err_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/ap_ctrl_driver.md
Name: ap_ctrl_driver

Overview:
- Synthesizable initiator for the HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue, ap_ctrl_chain semantics). This is the same protocol the dataflow monitors only observe.
- On a host command, launches N transactions into a child HLS module and keeps up to MAX_INFLIGHT outstanding.
- Timestamps each start in a small FIFO and reports per-transaction latency statistics.
- Sits between a test sequencer / CSR block and any ap_ctrl_chain child, e.g. a fetch or decode core.

Parameters:
- CNT_W, 32, width of transaction counters and cmd_count.
- LAT_W, 24, width of the timestamp counter and per-transaction latency.
- MAX_INFLIGHT, 4, timestamp FIFO depth and maximum started-but-not-done transactions (power of 2, at least 1).
- TIMEOUT, 1024, idle-cycle watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host requests a run.
- cmd_ready  out  1  high only in IDLE.
- cmd_count  in  CNT_W  number of transactions; sampled on cmd_valid&&cmd_ready.
- cons_stall  in  1  downstream back-pressure; forces ap_continue low.
- ap_start  out  1  start request to child.
- ap_ready  in  1  child accepted start.
- ap_done  in  1  child completed a transaction.
- ap_continue  out  1  permission for child to retire done.
- busy  out  1  state is RUN or DRAIN.
- run_done  out  1  one-cycle pulse on entry to IDLE from DONE.
- starts_issued  out  CNT_W  accepted starts in current/last run.
- dones_seen  out  CNT_W  accepted dones.
- lat_min  out  LAT_W  minimum done-minus-start cycles.
- lat_max  out  LAT_W  maximum.
- lat_sum  out  CNT_W+LAT_W  sum of latencies.
- err  out  1  sticky protocol error (cleared by reset or new command).
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (sync, active-high): state IDLE, ap_start=0, ap_continue=0, busy=0, run_done=0, all counters/stats 0, err=0, timeout=0, FIFO empty, timestamp counter 0. Takes effect mid-run: next cycle ap_start=0 and all in-flight state is discarded.
- States: IDLE -> RUN on cmd accept. Latch cmd_count, clear stats/err/timeout, set lat_min=all-ones internally. A cmd_count of 0 goes IDLE -> DONE directly.
- RUN -> DRAIN when starts_issued==cmd_count. DRAIN -> DONE when dones_seen==cmd_count. DONE -> IDLE after 1 cycle, pulsing run_done in the IDLE-entry cycle.
- Timestamp counter: free-running LAT_W bits, wraps. Latency = (ts_now - ts_start) mod 2^LAT_W.
- ap_start: registered. Rises in RUN when starts_issued<cmd_count and outstanding<MAX_INFLIGHT. Once high it stays high until sampled ap_ready=1 (start accepted), regardless of other conditions except reset.
- Start accept = ap_start&&ap_ready. Push ts_now into the FIFO, increment starts_issued and outstanding. ap_start may stay high back-to-back if the conditions still hold.
- ap_continue = (state RUN or DRAIN) && !cons_stall. It is combinational from the state register and cons_stall.
- Done accept = ap_done&&ap_continue. Pop the FIFO, compute latency, update min/max/sum, increment dones_seen, decrement outstanding.
- Simultaneous start accept and done accept in the same cycle:
  - With FIFO non-empty: the pop uses the head, the push goes to the tail, and outstanding is unchanged.
  - With FIFO empty: bypass, latency=0, and the FIFO stays empty.
- Done accept with FIFO empty and no same-cycle start: set err, ignore the done (counters unchanged).
- ap_ready while ap_start=0: ignored.
- At DONE with dones_seen=0: lat_min output reads 0. Otherwise lat_min is the stored minimum.
- Outputs starts_issued/dones_seen/lat_* hold their values in IDLE until the next command.
- lat_sum saturates at all-ones; no wrap.

Optional Feature:
- AP_CTRL_DRIVER_TIMEOUT_EN defined: in RUN/DRAIN, a watchdog counts cycles with neither a start accept nor a done accept, resetting on either.
  - On reaching TIMEOUT: set timeout, drop ap_start, go to DONE (run_done pulses normally).
- Not defined: no watchdog logic; timeout tied 0; the TIMEOUT parameter is unused.

Test Plan:
- Child with ap_ready=ap_start and ap_done 3 cycles after start, cmd_count=5 -> starts_issued=5, dones_seen=5, lat_min=lat_max=3, lat_sum=15, one run_done pulse, err=0.
- Child holds ap_ready low 4 cycles after ap_start rises -> ap_start remains high all 4 cycles, exactly one start counted.
- Child never asserts done, MAX_INFLIGHT=4, cmd_count=10 -> exactly 4 starts, then ap_start stays 0; busy=1 indefinitely (timeout disabled).
- cons_stall=1 for 6 cycles while child asserts ap_done -> no done accepted during stall; done counted on first cycle after stall drop, latency includes the stall.
- Spurious ap_done with zero outstanding -> err=1, dones_seen unchanged. Next command -> err cleared. Reset asserted mid-run (cmd_count=8, 3 started) -> next cycle ap_start=0, busy=0, all counters 0.
- With AP_CTRL_DRIVER_TIMEOUT_EN and TIMEOUT=16, child never readies -> timeout=1 after 16 idle cycles, state DONE, run_done pulse, starts_issued=0.
